// File: rtl/tictactoe_pkg.sv
// Shared types, cell codes and winning-line table for the tic-tac-toe result checker.
package tictactoe_pkg;

  typedef logic [1:0] cell_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam cell_t EMPTY_CODE = 2'b00;
  localparam cell_t P0_CODE    = 2'b01;
  localparam cell_t P1_CODE    = 2'b10;

  localparam int unsigned NumCells = 9;
  localparam int unsigned NumLines = 8;
  localparam int unsigned BoardW   = 2 * NumCells;

  // 0-based cell indices of each winning line: rows, columns, then both diagonals.
  localparam logic [3:0] LINE_CELLS [NumLines][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Extract the cell at 0-based position idx from a packed board.
  function automatic cell_t cell_at(input logic [BoardW-1:0] board, input logic [3:0] idx);
    return board[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/line_eval.sv
// Decides whether a single player owns all three cells of one line.
module line_eval
  import tictactoe_pkg::*;
(
  input  cell_t cell_a,
  input  cell_t cell_b,
  input  cell_t cell_c,
  output logic  owned,
  output logic  owner
);

  logic all_p0;
  logic all_p1;

  // Illegal code 2'b11 matches neither player, so it never completes a line.
  always_comb begin
    all_p0 = (cell_a == P0_CODE) && (cell_b == P0_CODE) && (cell_c == P0_CODE);
    all_p1 = (cell_a == P1_CODE) && (cell_b == P1_CODE) && (cell_c == P1_CODE);
    owned  = all_p0 || all_p1;
    owner  = all_p1;
  end

endmodule

// File: rtl/board_result_checker.sv
// Snapshots the board on a check request and scans the eight winning lines one per clock,
// reporting win (player and line), draw, or neither.
module board_result_checker
  import tictactoe_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              check,
  input  logic [BoardW-1:0] board,
  output logic              busy,
  output logic              done,
  output logic              win,
  output logic              winner_id,
  output logic [2:0]        win_line,
  output logic              draw
);

  state_t            state_q, state_d;
  logic [2:0]        line_idx_q, line_idx_d;
  logic [BoardW-1:0] snapshot_q, snapshot_d;
  logic              win_q, win_d;
  logic              winner_id_q, winner_id_d;
  logic [2:0]        win_line_q, win_line_d;
  logic              draw_q, draw_d;

  cell_t cell_a, cell_b, cell_c;
  logic  line_owned;
  logic  line_owner;
  logic  board_full;

  // Select the three snapshot cells of the line currently under evaluation.
  always_comb begin
    cell_a = cell_at(snapshot_q, LINE_CELLS[line_idx_q][0]);
    cell_b = cell_at(snapshot_q, LINE_CELLS[line_idx_q][1]);
    cell_c = cell_at(snapshot_q, LINE_CELLS[line_idx_q][2]);
  end

  line_eval u_line_eval (
    .cell_a (cell_a),
    .cell_b (cell_b),
    .cell_c (cell_c),
    .owned  (line_owned),
    .owner  (line_owner)
  );

  // Board is full when no snapshot cell is empty; 2'b11 counts as occupied.
  always_comb begin
    board_full = 1'b1;
    for (int i = 0; i < NumCells; i++) begin
      if (snapshot_q[2*i +: 2] == EMPTY_CODE) begin
        board_full = 1'b0;
      end
    end
  end

  // Next-state logic for the scan FSM, line counter, snapshot and result registers.
  always_comb begin
    state_d     = state_q;
    line_idx_d  = line_idx_q;
    snapshot_d  = snapshot_q;
    win_d       = win_q;
    winner_id_d = winner_id_q;
    win_line_d  = win_line_q;
    draw_d      = draw_q;

    unique case (state_q)
      IDLE: begin
        if (check) begin
          snapshot_d  = board;
          line_idx_d  = 3'd0;
          win_d       = 1'b0;
          winner_id_d = 1'b0;
          win_line_d  = 3'd0;
          draw_d      = 1'b0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (line_owned) begin
          // Lowest-indexed completed line is reported.
          win_d       = 1'b1;
          winner_id_d = line_owner;
          win_line_d  = line_idx_q;
          state_d     = DONE;
        end else if (line_idx_q == 3'd7) begin
          draw_d  = board_full;
          state_d = DONE;
        end else begin
          line_idx_d = line_idx_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      line_idx_q  <= 3'd0;
      snapshot_q  <= '0;
      win_q       <= 1'b0;
      winner_id_q <= 1'b0;
      win_line_q  <= 3'd0;
      draw_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_idx_q  <= line_idx_d;
      snapshot_q  <= snapshot_d;
      win_q       <= win_d;
      winner_id_q <= winner_id_d;
      win_line_q  <= win_line_d;
      draw_q      <= draw_d;
    end
  end

  // Status and results are driven straight from registers.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    win       = win_q;
    winner_id = winner_id_q;
    win_line  = win_line_q;
    draw      = draw_q;
  end

endmodule

// File: tb/tb_board_result_checker.sv
// Directed bench for board_result_checker: hand-computed boards, latencies and results.
module tb_board_result_checker;

  logic        clock;
  logic        reset;
  logic        check;
  logic [17:0] board;
  logic        busy;
  logic        done;
  logic        win;
  logic        winner_id;
  logic [2:0]  win_line;
  logic        draw;

  int checks;
  int errors;

  // Boards are written {pos9, pos8, ..., pos1}.
  localparam logic [17:0] BEmpty  = 18'b00_00_00_00_00_00_00_00_00;
  localparam logic [17:0] BRow0P0 = 18'b00_00_00_00_00_00_01_01_01;
  localparam logic [17:0] BAntiP1 = 18'b00_00_10_00_10_00_10_00_00;
  localparam logic [17:0] BDraw   = 18'b01_01_10_10_10_01_01_10_01;
  localparam logic [17:0] BDouble = 18'b00_00_01_00_00_01_01_01_01;
  localparam logic [17:0] BCol1P1 = 18'b00_10_00_00_10_00_00_10_00;
  localparam logic [17:0] BIllegal = 18'b11_11_11_11_11_11_11_11_11;

  board_result_checker dut (
    .clock     (clock),
    .reset     (reset),
    .check     (check),
    .board     (board),
    .busy      (busy),
    .done      (done),
    .win       (win),
    .winner_id (winner_id),
    .win_line  (win_line),
    .draw      (draw)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Wait (bounded) for done; cyc is the current cycle number on entry, updated on exit.
  task automatic wait_done(inout int cyc);
    while (!done && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  // Count done pulses over n cycles and expect none.
  task automatic expect_quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (done) pulses++;
    end
    check_val(tag, pulses, 0);
  endtask

  task automatic run_scan(input string tag, input logic [17:0] b, input int exp_cyc,
                          input logic exp_win, input logic exp_id, input logic [2:0] exp_line,
                          input logic exp_draw);
    int cyc;
    @(negedge clock);
    board = b;
    check = 1'b1;
    @(negedge clock);
    check = 1'b0;
    cyc = 1;
    check_val({tag, ".busy_scan"}, busy, 1);
    wait_done(cyc);
    check_val({tag, ".done_cycle"}, cyc, exp_cyc);
    check_val({tag, ".win"}, win, exp_win);
    check_val({tag, ".winner_id"}, winner_id, exp_id);
    check_val({tag, ".win_line"}, win_line, exp_line);
    check_val({tag, ".draw"}, draw, exp_draw);
    @(negedge clock);
    check_val({tag, ".done_one_cycle"}, done, 0);
    check_val({tag, ".busy_idle"}, busy, 0);
    check_val({tag, ".win_hold"}, win, exp_win);
    check_val({tag, ".draw_hold"}, draw, exp_draw);
  endtask

  initial begin
    int cyc;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    check  = 1'b0;
    board  = BEmpty;
    repeat (2) @(negedge clock);
    check_val("rst.busy", busy, 0);
    check_val("rst.done", done, 0);
    check_val("rst.win", win, 0);
    check_val("rst.winner_id", winner_id, 0);
    check_val("rst.win_line", win_line, 0);
    check_val("rst.draw", draw, 0);
    reset = 1'b0;

    run_scan("empty",   BEmpty,   9, 1'b0, 1'b0, 3'd0, 1'b0);
    run_scan("row0p0",  BRow0P0,  2, 1'b1, 1'b0, 3'd0, 1'b0);
    run_scan("antip1",  BAntiP1,  9, 1'b1, 1'b1, 3'd7, 1'b0);
    run_scan("drawful", BDraw,    9, 1'b0, 1'b0, 3'd0, 1'b1);
    run_scan("double",  BDouble,  2, 1'b1, 1'b0, 3'd0, 1'b0);
    run_scan("col1p1",  BCol1P1,  6, 1'b1, 1'b1, 3'd4, 1'b0);
    run_scan("illegal", BIllegal, 9, 1'b0, 1'b0, 3'd0, 1'b1);

    // Board written and check pulsed mid-scan: snapshot is used, the pulse is dropped.
    @(negedge clock);
    board = BEmpty;
    check = 1'b1;
    @(negedge clock);
    check = 1'b0;
    cyc = 1;
    @(negedge clock);
    cyc++;
    @(negedge clock);
    cyc++;
    board = BRow0P0;
    @(negedge clock);
    cyc++;
    check = 1'b1;
    @(negedge clock);
    cyc++;
    check = 1'b0;
    wait_done(cyc);
    check_val("snap.done_cycle", cyc, 9);
    check_val("snap.win", win, 0);
    check_val("snap.draw", draw, 0);
    expect_quiet("snap.no_requeue", 12);

    // Held check re-triggers right after DONE.
    @(negedge clock);
    board = BRow0P0;
    check = 1'b1;
    @(negedge clock);
    cyc = 1;
    wait_done(cyc);
    check_val("hold.first_done", cyc, 2);
    @(negedge clock);
    cyc++;
    wait_done(cyc);
    check_val("hold.second_done", cyc, 5);
    check_val("hold.win_line", win_line, 0);
    check = 1'b0;
    @(negedge clock);

    // Reset during a scan: no done, outputs cleared, then a normal scan.
    run_scan("prewin", BCol1P1, 6, 1'b1, 1'b1, 3'd4, 1'b0);
    @(negedge clock);
    board = BDraw;
    check = 1'b1;
    @(negedge clock);
    check = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_val("mrst.busy", busy, 0);
    check_val("mrst.done", done, 0);
    check_val("mrst.win", win, 0);
    check_val("mrst.winner_id", winner_id, 0);
    check_val("mrst.win_line", win_line, 0);
    check_val("mrst.draw", draw, 0);
    expect_quiet("mrst.no_done", 12);
    run_scan("post", BRow0P0, 2, 1'b1, 1'b0, 3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
